// File: rtl/fir_output_stage.sv
// FIR output stage: round, arithmetic shift and saturate the accumulated sum,
// then buffer it in a small FIFO behind a valid/ready port with drop/sat counters.
module fir_output_stage #(
  parameter int SUM_W = 24,
  parameter int OUT_W = 8,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [SUM_W-1:0]           sum_in,
  input  logic                       clear,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       ovf,
  output logic [7:0]                 sat_cnt,
  output logic [7:0]                 drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic signed [SUM_W:0] sum_ext, rnd, r_next, s1_r, sat_hi, sat_lo;
  logic                  s1_valid, s2_valid, clip;
  logic [OUT_W-1:0]      s2_next, s2_data;

  // One extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    rnd            = '0;
    rnd[SHIFT-1]   = 1'b1;
    sum_ext        = {sum_in[SUM_W-1], sum_in};
    r_next         = (sum_ext + rnd) >>> SHIFT;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sat_hi              = '0;
    sat_hi[OUT_W-2:0]   = '1;
    sat_lo              = '1;
    sat_lo[OUT_W-2:0]   = '0;
    clip                = 1'b0;
    s2_next             = s1_r[OUT_W-1:0];
    if (s1_r > sat_hi) begin
      s2_next = {1'b0, {(OUT_W-1){1'b1}}};
      clip    = 1'b1;
    end else if (s1_r < sat_lo) begin
      s2_next = {1'b1, {(OUT_W-1){1'b0}}};
      clip    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_r     <= r_next;
      s2_valid <= s1_valid;
      s2_data  <= s2_next;
    end
  end

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full, pop, push_en, drop, sat_ev;

  assign full    = (level == LVL_W'(DEPTH));
  assign pop     = out_valid && out_ready;
  assign push_en = s2_valid && (!full || pop);
  assign drop    = s2_valid && full && !pop;
  assign sat_ev  = s1_valid && clip;

  // NOTE: storage is not reset; out_valid gates out_data, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= s2_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  // clear has priority over any event landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf      <= 1'b0;
      sat_cnt  <= '0;
      drop_cnt <= '0;
    end else if (clear) begin
      ovf      <= 1'b0;
      sat_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (drop) ovf <= 1'b1;
      if (sat_ev && sat_cnt != 8'hFF)  sat_cnt  <= sat_cnt + 8'd1;
      if (drop && drop_cnt != 8'hFF)   drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
